// File: rtl/uart_recv_pkg.sv
// Shared UART definitions: FSM state encoding and the bit-period divider.
package uart_recv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_recv.sv
// 8N1 UART receiver with a 3-flop synchronizer, mid-bit sampling and framing-error detection.
// Start-bit fall to uart_done is about 9.5 bit periods plus sync delay; no backpressure, each byte is a 1-cycle strobe.
module uart_recv
   import uart_recv_pkg::*;
#(
   parameter int CLK_FREQ = 50000,
   parameter int UART_BPS = 9600
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rxd,
   output logic [7:0] uart_data,
   output logic       uart_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int          BPS_CNT   = calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam logic [15:0] CNT_MAX   = 16'(BPS_CNT - 1);
   localparam logic [15:0] SAMPLE_PT = 16'(BPS_CNT / 2);

   rx_state_e   state_q;
   logic [2:0]  rxd_sync_q;
   logic [15:0] clk_cnt_q;
   logic [15:0] clk_cnt_d;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        done_q;
   logic        err_q;
   logic        busy_q;
   logic        rxd_s;
   logic        start_det;
   logic        at_sample;
   logic        at_wrap;

   // rxd_sync_q[0] is the first stage; stage 1 is the sampled line, stage 2 only feeds edge detect
   assign rxd_s     = rxd_sync_q[1];
   assign start_det = rxd_sync_q[2] & ~rxd_sync_q[1];
   assign at_sample = (clk_cnt_q == SAMPLE_PT);
   assign at_wrap   = (clk_cnt_q == CNT_MAX);
   assign clk_cnt_d = at_wrap ? 16'd0 : clk_cnt_q + 16'd1;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         rxd_sync_q <= 3'b111;
         clk_cnt_q  <= 16'd0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rxd_sync_q <= {rxd_sync_q[1:0], uart_rxd};
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (start_det) begin
                  state_q   <= START;
                  clk_cnt_q <= 16'd0;
                  bit_cnt_q <= 3'd0;
               end
            end
            START: begin
               clk_cnt_q <= clk_cnt_d;
               if (at_sample && rxd_s) begin
                  state_q   <= IDLE;
                  clk_cnt_q <= 16'd0;
               end else if (at_wrap) begin
                  state_q <= DATA;
               end
            end
            DATA: begin
               clk_cnt_q <= clk_cnt_d;
               if (at_sample)
                  shift_q <= {rxd_s, shift_q[7:1]};
               if (at_wrap) begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7)
                     state_q <= STOP;
               end
            end
            STOP: begin
               clk_cnt_q <= clk_cnt_d;
               // leave at the stop-bit midpoint so a shortened stop bit still lets the next start through
               if (at_sample) begin
                  if (rxd_s) begin
                     data_q <= shift_q;
                     done_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  state_q   <= IDLE;
                  clk_cnt_q <= 16'd0;
               end
            end
         endcase
      end
   end

   assign uart_data = data_q;
   assign uart_done = done_q;
   assign frame_err = err_q;
   assign rx_busy   = busy_q;

endmodule
